mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two requester channels and the memory-side bus of the arbiter.
//   r0_*      : CPU requester (req/we/addr/wdata in, ack/rdata out)
//   r1_*      : program-loader/debug requester, same fields as r0
//   mem_*     : single memory port (en/we/addr/wdata out, rdata in)
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters plus memory)
// N must match the N of the mem_arbiter instance it is connected to.
interface mem_arbiter_if #(
    parameter int N = 32
);
    logic         r0_req;
    logic         r0_we;
    logic [N-1:0] r0_addr;
    logic [N-1:0] r0_wdata;
    logic         r0_ack;
    logic [N-1:0] r0_rdata;

    logic         r1_req;
    logic         r1_we;
    logic [N-1:0] r1_addr;
    logic [N-1:0] r1_wdata;
    logic         r1_ack;
    logic [N-1:0] r1_rdata;

    logic         mem_en;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_ack, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_ack, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_ack, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_ack, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester arbiter in front of a single fixed-latency memory port.
// One access at a time: IDLE picks a winner and latches its fields, ISSUE
// strobes the memory for one cycle, WAIT counts out MEM_LAT cycles and
// captures read data, RESP pulses the owner's ack for one cycle.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous, active-high reset
//   bus   : mem_arbiter_if.slave (requester channels and memory port)
//   owner : requester being served (0 when idle)
//   busy  : high in every state except IDLE
// Parameters:
//   N       : data/address width
//   MEM_LAT : cycles from mem_en to valid mem_rdata, 1..4
// Configuration macro:
//   ROUND_ROBIN_EN : when defined, simultaneous requests alternate between
//                    requesters; when undefined, r0 always wins a tie.
module mem_arbiter #(
    parameter int N       = 32,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic         owner,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t       state;
    state_t       next_state;

    logic         any_req;
    logic         grant_r1;
    logic         last_count;

    logic         lat_we;
    logic [N-1:0] lat_addr;
    logic [N-1:0] lat_wdata;
    logic [N-1:0] rdata;
    logic [2:0]   count;

`ifdef ROUND_ROBIN_EN
    // Remembers who was granted last; reset value 0 makes r1 the favourite
    // for the first tie after reset.
    logic         last_r1;
`endif

    // Winner selection for the current IDLE cycle. A lone request always
    // wins; only a tie consults the priority scheme.
    always_comb begin
        any_req = bus.r0_req | bus.r1_req;
`ifdef ROUND_ROBIN_EN
        grant_r1 = bus.r1_req & (~bus.r0_req | ~last_r1);
`else
        grant_r1 = bus.r1_req & ~bus.r0_req;
`endif
    end

    // Treat a count of 0 like 1 so a corrupted counter can never park the
    // FSM in WAIT.
    assign last_count = (count <= 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (last_count) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields are latched at grant so the memory sees stable values
    // even if the requester misbehaves; the latched address/data also stay
    // on mem_addr/mem_wdata between accesses. Read data is captured on the
    // last WAIT cycle for writes too; that value is simply ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner     <= 1'b0;
            count     <= 3'd0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= grant_r1;
                        lat_we    <= grant_r1 ? bus.r1_we    : bus.r0_we;
                        lat_addr  <= grant_r1 ? bus.r1_addr  : bus.r0_addr;
                        lat_wdata <= grant_r1 ? bus.r1_wdata : bus.r0_wdata;
                    end
                end
                ISSUE: begin
                    count <= LAT_INIT;
                end
                WAIT: begin
                    count <= count - 3'd1;
                    if (last_count) begin
                        rdata <= bus.mem_rdata;
                    end
                end
                RESP: begin
                    owner <= 1'b0;
                end
                default: begin
                    owner <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r1 <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_r1 <= grant_r1;
        end
    end
`endif

    // Strobes and acks decode straight from the state register, so an
    // asynchronous reset drops them without waiting for a clock edge.
    always_comb begin
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        bus.r0_ack = 1'b0;
        bus.r1_ack = 1'b0;
        busy       = (state != IDLE);
        case (state)
            ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_we = lat_we;
            end
            RESP: begin
                bus.r0_ack = ~owner;
                bus.r1_ack = owner;
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.r0_rdata  = rdata;
    assign bus.r1_rdata  = rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Two instances share clk/rst:
//   dut_a : MEM_LAT = 1
//   dut_b : MEM_LAT = 3
// Each instance has its own memory model whose read data is valid exactly
// MEM_LAT cycles after the mem_en cycle (garbage at any other time).
// Expected acks are pushed per instance/requester into queues; a negedge
// monitor pops and compares ack cycle and read data whenever an ack shows.
// Tie-break expectations follow the ROUND_ROBIN_EN macro of the build.
module tb_mem_arbiter;

    localparam int N     = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic [N-1:0] data;
        bit           check_data;
        int           cyc;
    } expect_t;

    logic clk;
    logic rst;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    logic owner_a;
    logic busy_a;
    logic owner_b;
    logic busy_b;

    logic         req_d   [2][2];
    logic         we_d    [2][2];
    logic [N-1:0] addr_d  [2][2];
    logic [N-1:0] wdata_d [2][2];

    expect_t exp_q [2][2][$];

    mem_arbiter_if #(.N(N)) bus_a ();
    mem_arbiter_if #(.N(N)) bus_b ();

    mem_arbiter #(.N(N), .MEM_LAT(LAT_A)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_a),
        .owner (owner_a),
        .busy  (busy_a)
    );

    mem_arbiter #(.N(N), .MEM_LAT(LAT_B)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_b),
        .owner (owner_b),
        .busy  (busy_b)
    );

    assign bus_a.r0_req   = req_d[0][0];
    assign bus_a.r0_we    = we_d[0][0];
    assign bus_a.r0_addr  = addr_d[0][0];
    assign bus_a.r0_wdata = wdata_d[0][0];
    assign bus_a.r1_req   = req_d[0][1];
    assign bus_a.r1_we    = we_d[0][1];
    assign bus_a.r1_addr  = addr_d[0][1];
    assign bus_a.r1_wdata = wdata_d[0][1];
    assign bus_b.r0_req   = req_d[1][0];
    assign bus_b.r0_we    = we_d[1][0];
    assign bus_b.r0_addr  = addr_d[1][0];
    assign bus_b.r0_wdata = wdata_d[1][0];
    assign bus_b.r1_req   = req_d[1][1];
    assign bus_b.r1_we    = we_d[1][1];
    assign bus_b.r1_addr  = addr_d[1][1];
    assign bus_b.r1_wdata = wdata_d[1][1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: unwritten words read back as a fixed pattern of the
    // address; dut_a additionally holds 0xDEADBEEF at 0x10.
    logic [N-1:0] wr_a [int];
    logic [N-1:0] wr_b [int];
    logic [N-1:0] rd_a;
    logic [N-1:0] pipe_b [3];

    function automatic logic [N-1:0] base_word(input int k, input logic [N-1:0] a);
        if (k == 0 && a == 32'h10) return 32'hDEAD_BEEF;
        return 32'hA000_0000 | a;
    endfunction

    function automatic logic [N-1:0] read_a(input logic [N-1:0] a);
        if (wr_a.exists(int'(a))) return wr_a[int'(a)];
        return base_word(0, a);
    endfunction

    function automatic logic [N-1:0] read_b(input logic [N-1:0] a);
        if (wr_b.exists(int'(a))) return wr_b[int'(a)];
        return base_word(1, a);
    endfunction

    always @(posedge clk) begin
        if (bus_a.mem_en) begin
            rd_a <= read_a(bus_a.mem_addr);
            if (bus_a.mem_we) wr_a[int'(bus_a.mem_addr)] = bus_a.mem_wdata;
        end else begin
            rd_a <= 32'hBAD0_0001;
        end
    end

    always @(posedge clk) begin
        if (bus_b.mem_en) begin
            pipe_b[0] <= read_b(bus_b.mem_addr);
            if (bus_b.mem_we) wr_b[int'(bus_b.mem_addr)] = bus_b.mem_wdata;
        end else begin
            pipe_b[0] <= 32'hBAD0_0003;
        end
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    assign bus_a.mem_rdata = rd_a;
    assign bus_b.mem_rdata = pipe_b[2];

    task automatic record(input string name, input bit ok,
                          input logic [N-1:0] actual, input logic [N-1:0] required);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)",
                     name, actual, required, cyc);
        end
    endtask

    task automatic check_output(input string name, input logic [N-1:0] actual,
                                input logic [N-1:0] required);
        record(name, actual === required, actual, required);
    endtask

    function automatic logic ack_of(input int k, input int r);
        case ({k[0], r[0]})
            2'b00:   return bus_a.r0_ack;
            2'b01:   return bus_a.r1_ack;
            2'b10:   return bus_b.r0_ack;
            default: return bus_b.r1_ack;
        endcase
    endfunction

    // {mem_en, mem_we, owner, busy}
    function automatic logic [3:0] flags(input int k);
        if (k == 0) return {bus_a.mem_en, bus_a.mem_we, owner_a, busy_a};
        return {bus_b.mem_en, bus_b.mem_we, owner_b, busy_b};
    endfunction

    function automatic logic [N-1:0] mem_addr_of(input int k);
        return (k == 0) ? bus_a.mem_addr : bus_b.mem_addr;
    endfunction

    function automatic logic [N-1:0] mem_wdata_of(input int k);
        return (k == 0) ? bus_a.mem_wdata : bus_b.mem_wdata;
    endfunction

    // Scoreboard monitor: every ack must match the head of its queue.
    task automatic score_ack(input int k, input int r, input logic ack,
                             input logic [N-1:0] rdata);
        expect_t e;
        if (!ack) return;
        if (exp_q[k][r].size() == 0) begin
            record($sformatf("unexpected_ack_%0d_r%0d", k, r), 1'b0, 32'd1, 32'd0);
            return;
        end
        e = exp_q[k][r].pop_front();
        if (e.cyc >= 0)
            check_output($sformatf("ack_cycle_%0d_r%0d", k, r), 32'(cyc), 32'(e.cyc));
        if (e.check_data)
            check_output($sformatf("rdata_%0d_r%0d", k, r), rdata, e.data);
    endtask

    always @(negedge clk) begin
        score_ack(0, 0, bus_a.r0_ack, bus_a.r0_rdata);
        score_ack(0, 1, bus_a.r1_ack, bus_a.r1_rdata);
        score_ack(1, 0, bus_b.r0_ack, bus_b.r0_rdata);
        score_ack(1, 1, bus_b.r1_ack, bus_b.r1_rdata);
        if (bus_a.r0_ack && bus_a.r1_ack)
            record("ack_exclusive_a", 1'b0, 32'd3, 32'd1);
        if (bus_b.r0_ack && bus_b.r1_ack)
            record("ack_exclusive_b", 1'b0, 32'd3, 32'd1);
    end

    task automatic push_exp(input int k, input int r, input logic [N-1:0] data,
                            input bit check_data, input int exp_cyc);
        expect_t e;
        e.data       = data;
        e.check_data = check_data;
        e.cyc        = exp_cyc;
        exp_q[k][r].push_back(e);
    endtask

    // Issues one request, holds it until ack, then releases it in the cycle
    // after the ack.
    task automatic apply_stimulus(input int k, input int r, input logic we,
                                  input logic [N-1:0] addr, input logic [N-1:0] wdata,
                                  input logic [N-1:0] data, input bit check_data,
                                  input int exp_cyc);
        int waited;
        push_exp(k, r, data, check_data, exp_cyc);
        we_d[k][r]    = we;
        addr_d[k][r]  = addr;
        wdata_d[k][r] = wdata;
        req_d[k][r]   = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack_of(k, r) && waited < 40);
        if (!ack_of(k, r))
            record($sformatf("ack_timeout_%0d_r%0d", k, r), 1'b0, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_d[k][r] = 1'b0;
    endtask

    task automatic check_at(input int k, input int cycle, input logic [3:0] exp_flags,
                            input string name);
        @(negedge clk);
        while (cyc < cycle) @(negedge clk);
        check_output(name, 32'(flags(k)), 32'(exp_flags));
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                req_d[k][r]   = 1'b0;
                we_d[k][r]    = 1'b0;
                addr_d[k][r]  = '0;
                wdata_d[k][r] = '0;
            end
        end

        // Reset values on both instances
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_output($sformatf("reset_flags_%0d", k), 32'(flags(k)), 32'd0);
            check_output($sformatf("reset_mem_addr_%0d", k), mem_addr_of(k), 32'd0);
            check_output($sformatf("reset_mem_wdata_%0d", k), mem_wdata_of(k), 32'd0);
            check_output($sformatf("reset_acks_%0d", k), 32'({ack_of(k, 0), ack_of(k, 1)}), 32'd0);
        end
        check_output("reset_rdata_a", bus_a.r0_rdata | bus_a.r1_rdata, 32'd0);
        check_output("reset_rdata_b", bus_b.r0_rdata | bus_b.r1_rdata, 32'd0);
        rst = 1'b0;
        next_cycle();

        // MEM_LAT=1 read by r0 of 0x10
        c = cyc;
        fork
            apply_stimulus(0, 0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, c + 3);
            begin
                check_at(0, c,     4'b0000, "r0_read_idle_c0");
                check_at(0, c + 1, 4'b1001, "r0_read_issue_c1");
                check_output("r0_read_addr_c1", mem_addr_of(0), 32'h10);
                check_at(0, c + 2, 4'b0001, "r0_read_wait_c2");
            end
        join
        next_cycle();

        // MEM_LAT=3 write by r1 of 0x12345678 to 0x20
        c = cyc;
        fork
            apply_stimulus(1, 1, 1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b0, c + 5);
            begin
                check_at(1, c + 1, 4'b1111, "r1_write_issue_c1");
                check_output("r1_write_addr", mem_addr_of(1), 32'h20);
                check_output("r1_write_wdata", mem_wdata_of(1), 32'h1234_5678);
                check_at(1, c + 2, 4'b0011, "r1_write_wait_c2");
                check_at(1, c + 5, 4'b0011, "r1_write_resp_c5");
                check_at(1, c + 6, 4'b0000, "r1_write_idle_c6");
            end
        join
        next_cycle();

        // Read the written word back through r0
        c = cyc;
        apply_stimulus(1, 0, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b1, c + 5);
        next_cycle();

        // r1 arrives during r0's WAIT and must queue behind it
        c = cyc;
        fork
            apply_stimulus(1, 0, 1'b0, 32'h40, 32'h0, 32'hA000_0040, 1'b1, c + 5);
            begin
                wait_cycle(c + 2);
                apply_stimulus(1, 1, 1'b0, 32'h44, 32'h0, 32'hA000_0044, 1'b1, c + 11);
            end
            begin
                check_at(1, c + 6, 4'b0000, "pending_r1_idle_gap");
                check_at(1, c + 7, 4'b1011, "pending_r1_issue");
                check_output("pending_r1_addr", mem_addr_of(1), 32'h44);
            end
        join
        next_cycle();

        // Both requesters held high for four transactions on dut_a
        c = cyc;
        we_d[0][0]   = 1'b0;
        addr_d[0][0] = 32'h30;
        we_d[0][1]   = 1'b0;
        addr_d[0][1] = 32'h31;
`ifdef ROUND_ROBIN_EN
        push_exp(0, 1, 32'hA000_0031, 1'b1, c + 3);
        push_exp(0, 0, 32'hA000_0030, 1'b1, c + 7);
        push_exp(0, 1, 32'hA000_0031, 1'b1, c + 11);
        push_exp(0, 0, 32'hA000_0030, 1'b1, c + 15);
`else
        push_exp(0, 0, 32'hA000_0030, 1'b1, c + 3);
        push_exp(0, 0, 32'hA000_0030, 1'b1, c + 7);
        push_exp(0, 0, 32'hA000_0030, 1'b1, c + 11);
        push_exp(0, 0, 32'hA000_0030, 1'b1, c + 15);
`endif
        req_d[0][0] = 1'b1;
        req_d[0][1] = 1'b1;
        wait_cycle(c + 16);
        req_d[0][0] = 1'b0;
        req_d[0][1] = 1'b0;
        check_at(0, c + 17, 4'b0000, "tie_released_idle");
        next_cycle();

        // Reset in the middle of a dut_b access aborts it with no ack
        c = cyc;
        we_d[1][0]   = 1'b0;
        addr_d[1][0] = 32'h50;
        req_d[1][0]  = 1'b1;
        wait_cycle(c + 3);
        check_output("busy_before_reset", 32'(flags(1)), 32'(4'b0001));
        rst = 1'b1;
        #1;
        check_output("reset_abort_flags", 32'(flags(1)), 32'd0);
        check_output("reset_abort_addr", mem_addr_of(1), 32'd0);
        req_d[1][0] = 1'b0;
        next_cycle();
        rst = 1'b0;
        c = cyc;
        check_at(1, c + 3, 4'b0000, "post_reset_quiet");
        next_cycle();

        // Fresh read after reset keeps standard timing
        c = cyc;
        apply_stimulus(1, 0, 1'b0, 32'h50, 32'h0, 32'hA000_0050, 1'b1, c + 5);

        repeat (5) next_cycle();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                check_output($sformatf("queue_drained_%0d_r%0d", k, r),
                             32'(exp_q[k][r].size()), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
